// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command scheduler.
// Frames are "!<T><d1><d0>"; T selects the MGU, GNU or both consumers.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTgt,
    StDhi,
    StDlo,
    StXfer
  } state_e;

  typedef enum logic [1:0] {
    ErrOverrun  = 2'd0,
    ErrTimeout  = 2'd1,
    ErrBadTgt   = 2'd2,
    ErrBadDigit = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    TgtM,
    TgtG,
    TgtB
  } target_e;

  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  function automatic logic is_digit(logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/uart_cmd_sched_if.sv
// Valid/ready command channels from the scheduler to the MGU and GNU consumers.
interface uart_cmd_sched_if;

  logic        mgu_valid;
  logic        mgu_ready;
  logic [15:0] mgu_data;
  logic        gnu_valid;
  logic        gnu_ready;
  logic [15:0] gnu_data;

  modport master (
    output mgu_valid, mgu_data, gnu_valid, gnu_data,
    input  mgu_ready, gnu_ready
  );

  modport slave (
    input  mgu_valid, mgu_data, gnu_valid, gnu_data,
    output mgu_ready, gnu_ready
  );

endinterface

// File: rtl/uart_cmd_out_slot.sv
// One output channel: holds valid/data until handshake; done means nothing pending next cycle.
module uart_cmd_out_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        ready,
  output logic        valid,
  output logic [15:0] data,
  output logic        done
);

  logic        valid_q;
  logic [15:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign done  = !valid_q || ready;

endmodule

// File: rtl/uart_cmd_sched.sv
// Parses "!<T><d1><d0>" frames from the UART receiver and delivers 16-bit commands.
// Define UART_CMD_TIMEOUT_EN to build the inter-byte timeout counter and TIMEOUT error.
module uart_cmd_sched
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 17360,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_dv,
  input  logic [7:0]           rx_byte,
  uart_cmd_sched_if.master     cmd,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e         state_q, state_d;
  target_e        tgt_q, tgt_d;
  logic [3:0]     hi_q, hi_d;
  logic           load;
  logic [15:0]    cmd_word;
  logic           err_valid;
  err_code_e      err_sel;
  logic           mgu_done, gnu_done;

  err_code_e              err_code_q;
  logic                   err_pulse_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CLKS + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            parsing;
  logic            tmo_hit;

  assign parsing = state_q inside {StTgt, StDhi, StDlo};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit   = parsing && !rx_dv && (tmo_cnt_q == CntW'(TIMEOUT_CLKS - 1));
  assign tmo_cnt_d = (rx_dv || !parsing || tmo_hit) ? '0 : tmo_cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_clks;
  assign unused_timeout_clks = ^TIMEOUT_CLKS;
`endif

  assign cmd_word = {4'h0, hi_q, 4'h0, 4'(rx_byte - CH_0)};

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    hi_d      = hi_q;
    load      = 1'b0;
    err_valid = 1'b0;
    err_sel   = ErrOverrun;

    unique case (state_q)
      StIdle: begin
        if (rx_dv && (rx_byte == CH_BANG)) state_d = StTgt;
      end
      StTgt: begin
        if (rx_dv) begin
          if (rx_byte == CH_M) begin
            tgt_d   = TgtM;
            state_d = StDhi;
          end else if (rx_byte == CH_G) begin
            tgt_d   = TgtG;
            state_d = StDhi;
          end else if (rx_byte == CH_B) begin
            tgt_d   = TgtB;
            state_d = StDhi;
          end else if (rx_byte != CH_BANG) begin
            err_valid = 1'b1;
            err_sel   = ErrBadTgt;
            state_d   = StIdle;
          end
        end
      end
      StDhi, StDlo: begin
        if (rx_dv) begin
          if (is_digit(rx_byte)) begin
            if (state_q == StDhi) begin
              hi_d    = 4'(rx_byte - CH_0);
              state_d = StDlo;
            end else begin
              load    = 1'b1;
              state_d = StXfer;
            end
          end else if (rx_byte == CH_BANG) begin
            state_d = StTgt;
          end else begin
            err_valid = 1'b1;
            err_sel   = ErrBadDigit;
            state_d   = StIdle;
          end
        end
      end
      StXfer: begin
        // Bytes are dropped while delivering, even on the completing cycle.
        if (rx_dv) begin
          err_valid = 1'b1;
          err_sel   = ErrOverrun;
        end
        if (mgu_done && gnu_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    if (tmo_hit) begin
      err_valid = 1'b1;
      err_sel   = ErrTimeout;
      state_d   = StIdle;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tgt_q   <= TgtM;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_code_q  <= ErrOverrun;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_valid;
      if (err_valid) begin
        err_code_q <= err_sel;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  uart_cmd_out_slot u_mgu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load && (tgt_q != TgtG)),
    .load_data (cmd_word),
    .ready     (cmd.mgu_ready),
    .valid     (cmd.mgu_valid),
    .data      (cmd.mgu_data),
    .done      (mgu_done)
  );

  uart_cmd_out_slot u_gnu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load && (tgt_q != TgtM)),
    .load_data (cmd_word),
    .ready     (cmd.gnu_ready),
    .valid     (cmd.gnu_valid),
    .data      (cmd.gnu_data),
    .done      (gnu_done)
  );

  assign busy      = (state_q == StXfer);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Bench for uart_cmd_sched: hand-derived vector table, directed corner cases and random traffic
// checked every cycle against a frame-level reference model.
module tb_uart_cmd_sched;

  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       busy;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  uart_cmd_sched_if ifc ();

  uart_cmd_sched #(
    .TIMEOUT_CLKS (TMO),
    .ERR_CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .cmd       (ifc),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes accepted into the current frame plus pending deliveries.
  logic [7:0]  frame[$];
  logic        m_pend, g_pend;
  logic [15:0] m_dat, g_dat;
  logic        m_ep;
  logic [1:0]  m_ec;
  logic [7:0]  m_cnt;
  int          silence;

  typedef struct {
    logic        dv;
    logic [7:0]  b;
    logic        mr;
    logic        gr;
    logic [45:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic dv, logic [7:0] b, logic mr, logic gr, logic mv,
                             logic [15:0] md, logic gv, logic [15:0] gd, logic bz,
                             logic ep, logic [1:0] ec, logic [7:0] cnt);
    vec_t r;
    r.dv  = dv;
    r.b   = b;
    r.mr  = mr;
    r.gr  = gr;
    r.exp = {mv, md, gv, gd, bz, ep, ec, cnt};
    return r;
  endfunction

  function automatic logic [45:0] outs();
    return {ifc.mgu_valid, ifc.mgu_data, ifc.gnu_valid, ifc.gnu_data, busy, err_pulse,
            err_code, err_cnt};
  endfunction

  function automatic logic [45:0] model_outs();
    return {m_pend, m_dat, g_pend, g_dat, m_pend || g_pend, m_ep, m_ec, m_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_pend  = 1'b0;
    g_pend  = 1'b0;
    m_dat   = '0;
    g_dat   = '0;
    m_ep    = 1'b0;
    m_ec    = 2'd0;
    m_cnt   = '0;
    silence = 0;
  endtask

  task automatic model_update();
    int          e;
    logic [15:0] c;
    e = -1;
    if (m_pend || g_pend) begin
      if (rx_dv) e = 0;
      if (ifc.mgu_ready) m_pend = 1'b0;
      if (ifc.gnu_ready) g_pend = 1'b0;
    end else if (rx_dv) begin
      silence = 0;
      if (frame.size() == 0) begin
        if (rx_byte == 8'h21) frame.push_back(rx_byte);
      end else if (rx_byte == 8'h21) begin
        frame.delete();
        frame.push_back(rx_byte);
      end else if (frame.size() == 1) begin
        if (rx_byte inside {8'h4D, 8'h47, 8'h42}) frame.push_back(rx_byte);
        else begin
          e = 2;
          frame.delete();
        end
      end else if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
        frame.push_back(rx_byte);
        if (frame.size() == 4) begin
          c = {8'(frame[2] - 8'h30), 8'(frame[3] - 8'h30)};
          if (frame[1] != 8'h47) begin
            m_pend = 1'b1;
            m_dat  = c;
          end
          if (frame[1] != 8'h4D) begin
            g_pend = 1'b1;
            g_dat  = c;
          end
          frame.delete();
        end
      end else begin
        e = 3;
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      silence++;
`ifdef UART_CMD_TIMEOUT_EN
      if (silence == TMO) begin
        e = 1;
        frame.delete();
        silence = 0;
      end
`endif
    end
    m_ep = (e >= 0);
    if (e >= 0) begin
      m_ec = 2'(e);
      if (m_cnt != 8'hFF) m_cnt++;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance, then compare at the next fall.
  task automatic step(input logic dv, input logic [7:0] b, input logic mr, input logic gr);
    rx_dv         = dv;
    rx_byte       = b;
    ifc.mgu_ready = mr;
    ifc.gnu_ready = gr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("model", 64'(outs()), 64'(model_outs()));
  endtask

  task automatic send(input string s, input logic mr, input logic gr);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], mr, gr);
  endtask

  initial begin
    int pulses;
    logic [7:0] pool;
    string sym;
    sym = "!MGB";

    rst_n         = 1'b0;
    rx_dv         = 1'b0;
    rx_byte       = '0;
    ifc.mgu_ready = 1'b0;
    ifc.gnu_ready = 1'b0;
    model_reset();
    #2;
    chk("reset_state", 64'(outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "!M37", "!X", "!G1A", overrun during XFER, "!G99", "!M!G34"
    tbl.push_back(v(1, 8'h21, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h4D, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h33, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h37, 1, 0, 1, 16'h0307, 0, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h21, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h58, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 1, 2, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'h21, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'h47, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'h31, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'h41, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 1, 3, 2));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(v(1, 8'h21, 0, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(v(1, 8'h4D, 0, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(v(1, 8'h31, 0, 0, 0, 16'h0307, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(v(1, 8'h32, 0, 0, 1, 16'h0102, 0, 16'h0000, 1, 0, 3, 2));
    tbl.push_back(v(1, 8'h21, 0, 0, 1, 16'h0102, 0, 16'h0000, 1, 1, 0, 3));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 16'h0102, 0, 16'h0000, 1, 0, 0, 3));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 16'h0102, 0, 16'h0000, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h21, 1, 1, 0, 16'h0102, 0, 16'h0000, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h47, 1, 1, 0, 16'h0102, 0, 16'h0000, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h39, 1, 1, 0, 16'h0102, 0, 16'h0000, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h39, 1, 1, 0, 16'h0102, 1, 16'h0909, 1, 0, 0, 3));
    tbl.push_back(v(0, 8'h00, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h21, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h4D, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h21, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h47, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h33, 1, 1, 0, 16'h0102, 0, 16'h0909, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h34, 1, 1, 0, 16'h0102, 1, 16'h0304, 1, 0, 0, 3));
    tbl.push_back(v(0, 8'h00, 1, 1, 0, 16'h0102, 0, 16'h0304, 0, 0, 0, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].dv, tbl[i].b, tbl[i].mr, tbl[i].gr);
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end

    // Broadcast: GNU accepts at once, MGU stalls for five cycles.
    send("!B5", 1'b0, 1'b1);
    step(1'b1, 8'h32, 1'b0, 1'b1);
    chk("b_both_valid", 64'({ifc.mgu_valid, ifc.gnu_valid, busy}), 64'(3'b111));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("b_gnu_first", 64'({ifc.mgu_valid, ifc.gnu_valid, busy}), 64'(3'b101));
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("b_still_busy", 64'(busy), 64'(1));
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("b_done", 64'({ifc.mgu_valid, busy, ifc.mgu_data, ifc.gnu_data}),
        64'({1'b0, 1'b0, 16'h0502, 16'h0502}));

    // Inter-byte silence after "!M".
    send("!M", 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < TMO; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      if (err_pulse) pulses++;
    end
`ifdef UART_CMD_TIMEOUT_EN
    chk("tmo_pulse_last", 64'({err_pulse, err_code}), 64'({1'b1, 2'd1}));
    chk("tmo_pulse_count", 64'(pulses), 64'd1);
`else
    chk("tmo_no_pulse", 64'(pulses), 64'd0);
    send("45", 1'b0, 1'b1);
    chk("tmo_late_frame", 64'({ifc.mgu_valid, ifc.mgu_data}), 64'({1'b1, 16'h0405}));
    step(1'b0, 8'h00, 1'b1, 1'b1);
`endif

    // Asynchronous reset with a command outstanding.
    send("!M12", 1'b0, 1'b0);
    chk("pre_reset_valid", 64'(ifc.mgu_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("mid_reset", 64'(outs()), 64'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 8'h33, 1'b1, 1'b1);
    chk("partial_dropped", 64'({ifc.mgu_valid, ifc.gnu_valid}), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int k = 0; k < TMO + 4; k++)
          step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2:       pool = sym[$urandom_range(0, 3)];
          3, 4, 5, 6, 7: pool = 8'h30 + 8'($urandom_range(0, 9));
          default:       pool = 8'($urandom_range(0, 255));
        endcase
        step(1'($urandom_range(0, 9) < 6), pool, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sched.md
Name: uart_cmd_sched

Overview:
- Controller between the UART receiver (byte + data-valid strobe) and the two command consumers, MGU and GNU.
- Parses 4-byte ASCII frames "!<T><d1><d0>", validates them, and delivers the 16-bit command over independent valid/ready handshakes.
- For target 'B' it drives both consumers at once.
- Reports framing errors, inter-byte timeouts and overruns instead of silently latching garbage.

Parameters:
- TIMEOUT_CLKS, 17360, max clk cycles between bytes of one frame (4 byte-times at 434 clks/bit).
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_dv  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received UART byte
- mgu_valid  out  1  command available to MGU
- mgu_ready  in  1  MGU accepts command
- mgu_data  out  16  MGU command
- gnu_valid  out  1  command available to GNU
- gnu_ready  in  1  GNU accepts command
- gnu_data  out  16  GNU command
- busy  out  1  frame delivery in progress (state XFER)
- err_pulse  out  1  one-cycle error strobe
- err_code  out  2  last error: 0 OVERRUN, 1 TIMEOUT, 2 BAD_TGT, 3 BAD_DIGIT
- err_cnt  out  ERR_CNT_W  saturating count of err_pulse events

Behaviour:
- Reset (async assert, sync release): state IDLE; all valids 0, data 0, busy 0, err_pulse 0, err_code 0, err_cnt 0, timeout counter 0.
- Only cycles with rx_dv=1 advance the parser.

State transitions:
- IDLE: byte 0x21 -> TGT. Any other byte is ignored, no error.
- TGT: 0x4D/0x47/0x42 latch target M/G/B -> DHI. 0x21 -> stay TGT (resync, no error). Other -> BAD_TGT, IDLE.
- DHI: 0x30..0x39 latch hi = byte-0x30 -> DLO. 0x21 -> TGT (resync). Other -> BAD_DIGIT, IDLE.
- DLO: 0x30..0x39 -> XFER. 0x21 -> TGT. Other -> BAD_DIGIT, IDLE.
- XFER: cmd = {8'(hi), 8'(byte_lo-0x30)}. The result is 0x0000..0x0909, i.e. each byte is the binary value of its digit.

Delivery in XFER:
- On entry (the cycle after the final digit's rx_dv, latency 1), the selected target(s) get valid=1 and data=cmd.
- The data register of a non-selected target keeps its previous value.
- Transfer occurs on a posedge with valid&&ready; that valid drops the following cycle.
- Data stays stable while valid=1.
- For B, each side completes independently. XFER exits to IDLE the cycle after the last pending handshake.
- ready with valid=0 has no effect.

Overrun:
- Any rx_dv while in XFER (including the completing cycle) drops the byte and raises OVERRUN.

Timeout:
- Counter clears on every rx_dv and on entering TGT; it increments in TGT/DHI/DLO.
- Reaching TIMEOUT_CLKS raises TIMEOUT and returns to IDLE.
- If rx_dv and expiry fall in the same cycle, the byte wins and the counter clears.

Errors:
- Each error gives err_pulse=1 for exactly one cycle and updates err_code, which holds until the next error.
- err_cnt increments and saturates at all-ones.
- At most one error source is possible per cycle.

Reset mid-operation: all valids drop immediately and any partial frame is discarded.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- Defined: inter-byte timeout counter and TIMEOUT error present as above.
- Undefined: no counter logic; parse states wait indefinitely; err_code 1 is never produced. TIMEOUT_CLKS remains legal but unused.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (IDLE, TGT, DHI, DLO, XFER)
  - err_code enum
  - ASCII constants CH_BANG=0x21, CH_M=0x4D, CH_G=0x47, CH_B=0x42, CH_0=0x30, CH_9=0x39
  - target enum (M, G, B)
- Sub-module uart_cmd_out_slot: a single valid/data register with load/handshake-clear and done flag. It is instantiated twice (MGU, GNU).

Test Plan:
- Bytes 0x21,0x4D,0x33,0x37 with mgu_ready=1 -> mgu_valid for 1 cycle starting 1 cycle after last rx_dv, mgu_data=0x0307; gnu_valid stays 0; no err.
- Frame "!B52" with gnu_ready=1 and mgu_ready held 0 for 5 cycles -> gnu handshake first, busy=1 until mgu handshake; both data=0x0502; IDLE the cycle after.
- "!X" -> err_pulse, err_code=2, err_cnt=1, no valid. Then "!G1A" -> err_code=3, err_cnt=2.
- "!M" followed by silence for TIMEOUT_CLKS cycles -> err_code=1 (macro defined). With the macro undefined: no error, and a later "45" completes mgu_data=0x0405.
- "!M12" with mgu_ready=0, then byte 0x21 during XFER -> err_code=0, byte dropped; after ready, the next "!G99" delivers gnu_data=0x0909.
- "!M!G34" -> resync, no error, gnu_data=0x0304. Assert rst_n=0 mid-frame -> all outputs return to reset values immediately.
